// File: rtl/inv_substitution_layer_seq_pkg.sv
// ascon_pack: shared state type, FSM encoding and inverse S-box table for the inverse substitution layer
// Contents:
//   type_state     five 64-bit words x0..x4, index 0 is x0
//   fsm_t          IDLE / BUSY / DONE controller states
//   INV_SBOX_TABLE 32-entry inverse S-box, index 0 first
package ascon_pack;
   typedef logic [0:4][63:0] type_state;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;
   localparam logic [0:31][4:0] INV_SBOX_TABLE = {
      5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
      5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
      5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
      5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
   };
endpackage

// File: rtl/inv_substitution_layer_seq_if.sv
// inv_substitution_layer_seq_if: request/result bundle of the inverse substitution layer
// Signals:
//   start_i  request, accepted when ready_o=1
//   ready_o  block idle
//   state_i  state to invert
//   valid_o  state_o holds a complete result
//   ack_i    consumer takes the result
//   state_o  inverse-substituted state
// Modports: master drives requests and acks, slave is the layer itself.
interface inv_substitution_layer_seq_if;
   import ascon_pack::*;
   logic start_i;
   logic ready_o;
   logic valid_o;
   logic ack_i;
   type_state state_i;
   type_state state_o;
   modport master (output start_i, state_i, ack_i, input ready_o, valid_o, state_o);
   modport slave (input start_i, state_i, ack_i, output ready_o, valid_o, state_o);
endinterface

// File: rtl/inv_substitution_layer_seq_inv_sbox.sv
// inv_sbox: combinational 5-bit inverse S-box lookup
// Ports:
//   x_i  column word {x0,x1,x2,x3,x4}, x0 as MSB
//   y_o  inverse S-box of x_i, same bit order
module inv_sbox
   import ascon_pack::*;
(
   input  logic [4:0] x_i,
   output logic [4:0] y_o
);
   assign y_o = INV_SBOX_TABLE[x_i];
endmodule

// File: rtl/inv_substitution_layer_seq.sv
// inv_substitution_layer_seq: sequential inverse S-box layer, COLS_PER_CYCLE columns per cycle
// Ports:
//   clock_i   single clock, rising edge
//   resetb_i  asynchronous active-low reset
//   bus       slave side of the request/result bundle
module inv_substitution_layer_seq
   import ascon_pack::*;
#(
   parameter int COLS_PER_CYCLE = 8
) (
   input logic clock_i,
   input logic resetb_i,
   inv_substitution_layer_seq_if.slave bus
);
   localparam int SLICES = 64 / COLS_PER_CYCLE;
   localparam int CNT_W = SLICES > 1 ? $clog2(SLICES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);
   fsm_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   type_state work_q, work_d;
   logic [COLS_PER_CYCLE-1:0][5:0] col;
   logic [COLS_PER_CYCLE-1:0][4:0] sb_in, sb_out;
   // Lane c of the S-box bank reads column cnt*COLS_PER_CYCLE + c.
   for (genvar c = 0; c < COLS_PER_CYCLE; c++) begin : g_lane
      assign col[c] = 6'(int'(cnt_q) * COLS_PER_CYCLE + c);
      assign sb_in[c] = {work_q[0][col[c]], work_q[1][col[c]], work_q[2][col[c]], work_q[3][col[c]], work_q[4][col[c]]};
      inv_sbox u_inv_sbox (.x_i(sb_in[c]), .y_o(sb_out[c]));
   end
   // Each column statically knows its slice and lane, so writeback needs no dynamic bit writes.
   for (genvar j = 0; j < 64; j++) begin : g_wb
      localparam int LANE = j % COLS_PER_CYCLE;
      logic hit;
      assign hit = int'(cnt_q) == j / COLS_PER_CYCLE;
      assign {work_d[0][j], work_d[1][j], work_d[2][j], work_d[3][j], work_d[4][j]} =
         hit ? sb_out[LANE] : {work_q[0][j], work_q[1][j], work_q[2][j], work_q[3][j], work_q[4][j]};
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = bus.start_i ? BUSY : IDLE;
         BUSY:    state_d = cnt_q == LAST ? DONE : BUSY;
         DONE:    state_d = bus.ack_i ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q <= IDLE;
         cnt_q <= '0;
         work_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && bus.start_i) begin
            work_q <= bus.state_i;
            cnt_q <= '0;
         end else if (state_q == BUSY) begin
            work_q <= work_d;
            cnt_q <= cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
         end
      end
   end
   assign bus.ready_o = state_q == IDLE;
   assign bus.valid_o = state_q == DONE;
   assign bus.state_o = work_q;
endmodule

// File: tb/tb_inv_substitution_layer_seq.sv
// tb_inv_substitution_layer_seq: directed bench for the inverse substitution layer at 1, 8 and 64 columns per cycle
module tb_inv_substitution_layer_seq;
   import ascon_pack::*;
   localparam logic [0:31][4:0] FWD = {
      5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
      5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
      5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
      5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
   };
   localparam logic [0:31][4:0] INV_EXP = {
      5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
      5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
      5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
      5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
   };
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0;
   logic ack = 1'b0;
   type_state din = '0;
   logic [2:0] rdy, vld;
   int n_chk = 0;
   int n_pass = 0;
   always #5 clk = ~clk;
   inv_substitution_layer_seq_if b1 ();
   inv_substitution_layer_seq_if b8 ();
   inv_substitution_layer_seq_if b64 ();
   assign b1.start_i = start;
   assign b8.start_i = start;
   assign b64.start_i = start;
   assign b1.ack_i = ack;
   assign b8.ack_i = ack;
   assign b64.ack_i = ack;
   assign b1.state_i = din;
   assign b8.state_i = din;
   assign b64.state_i = din;
   assign rdy = {b1.ready_o, b8.ready_o, b64.ready_o};
   assign vld = {b1.valid_o, b8.valid_o, b64.valid_o};
   inv_substitution_layer_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clock_i(clk), .resetb_i(rst_n), .bus(b1));
   inv_substitution_layer_seq #(.COLS_PER_CYCLE(8)) u_dut8 (.clock_i(clk), .resetb_i(rst_n), .bus(b8));
   inv_substitution_layer_seq #(.COLS_PER_CYCLE(64)) u_dut64 (.clock_i(clk), .resetb_i(rst_n), .bus(b64));
   task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask
   function automatic type_state fwd_sub(input type_state s);
      type_state r;
      for (int i = 0; i < 64; i++)
         {r[0][i], r[1][i], r[2][i], r[3][i], r[4][i]} = FWD[{s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]}];
      return r;
   endfunction
   task automatic accept(input string tag, input type_state s);
      check({tag, ":ready"}, rdy, 3'b111);
      din = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask
   // Waits for all three results, checks latency and value, optionally applies backpressure, then acks.
   task automatic finish(input string tag, input type_state exp, input bit pulse_busy, input bit hold);
      type_state r1, r8, r64;
      int l1, l8, l64;
      r1 = '0;
      r8 = '0;
      r64 = '0;
      l1 = 0;
      l8 = 0;
      l64 = 0;
      for (int k = 1; k <= 80 && (l1 == 0 || l8 == 0 || l64 == 0); k++) begin
         @(posedge clk);
         #1;
         if (b1.valid_o && l1 == 0) begin l1 = k; r1 = b1.state_o; end
         if (b8.valid_o && l8 == 0) begin l8 = k; r8 = b8.state_o; end
         if (b64.valid_o && l64 == 0) begin l64 = k; r64 = b64.state_o; end
         start = pulse_busy && k < 4;
         if (start) din = ~din;
      end
      start = 1'b0;
      check({tag, ":lat1"}, l1, 64);
      check({tag, ":lat8"}, l8, 8);
      check({tag, ":lat64"}, l64, 1);
      check({tag, ":res1"}, r1, exp);
      check({tag, ":res8"}, r8, exp);
      check({tag, ":res64"}, r64, exp);
      if (hold) begin
         for (int k = 0; k < 20; k++) begin
            start = k[0];
            din = ~din;
            @(posedge clk);
            #1;
            check({tag, ":hold_valid"}, vld, 3'b111);
            check({tag, ":hold_ready"}, rdy, 3'b000);
            check({tag, ":hold_st1"}, b1.state_o, exp);
            check({tag, ":hold_st8"}, b8.state_o, exp);
            check({tag, ":hold_st64"}, b64.state_o, exp);
         end
         start = 1'b1;
         ack = 1'b1;
         check({tag, ":ack_cycle_ready"}, rdy, 3'b000);
         @(posedge clk);
         #1;
         start = 1'b0;
         ack = 1'b0;
         check({tag, ":post_ack_ready"}, rdy, 3'b111);
         check({tag, ":post_ack_valid"}, vld, 3'b000);
      end else begin
         ack = 1'b1;
         @(posedge clk);
         #1;
         ack = 1'b0;
      end
   endtask
   initial begin
      type_state s, e;
      logic [4:0] w;
      #1 rst_n = 1'b0;
      #2;
      check("reset_ready", rdy, 3'b111);
      check("reset_valid", vld, 3'b000);
      check("reset_state8", b8.state_o, '0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      accept("zero", '0);
      finish("zero", {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0}, 1'b1, 1'b0);
      accept("roundtrip", {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0});
      finish("roundtrip", '0, 1'b0, 1'b0);
      for (int c = 0; c < 64; c++) begin
         w = 5'(c % 32);
         {s[0][c], s[1][c], s[2][c], s[3][c], s[4][c]} = w;
         {e[0][c], e[1][c], e[2][c], e[3][c], e[4][c]} = INV_EXP[w];
      end
      accept("columns", s);
      finish("columns", e, 1'b0, 1'b0);
      for (int r = 0; r < 5; r++) s[r] = {$urandom, $urandom};
      accept("backpressure", fwd_sub(s));
      finish("backpressure", s, 1'b0, 1'b1);
      for (int r = 0; r < 5; r++) s[r] = {$urandom, $urandom};
      accept("abort", fwd_sub(s));
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_ready", rdy, 3'b111);
      check("abort_valid", vld, 3'b000);
      check("abort_st1", b1.state_o, '0);
      check("abort_st8", b8.state_o, '0);
      check("abort_st64", b64.state_o, '0);
      @(negedge clk);
      rst_n = 1'b1;
      din = fwd_sub(s);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("first_accept_ready", rdy, 3'b000);
      finish("after_abort", s, 1'b0, 1'b0);
      for (int n = 0; n < 1000; n++) begin
         for (int r = 0; r < 5; r++) s[r] = {$urandom, $urandom};
         accept("rand", fwd_sub(s));
         finish("rand", s, 1'b0, 1'b0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/inv_substitution_layer_seq.md
INV_SUBSTITUTION_LAYER_SEQ -- requirements
Module: inv_substitution_layer_seq

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 8, giving the inverse S-box columns processed per cycle; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 SHALL have port clock_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetb_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start_i  input  1  request; a transfer occurs on a cycle with start_i=1 and ready_o=1.
REQ-005 SHALL have port ready_o  output  1  block is idle and accepts a new state.
REQ-006 SHALL have port state_i  input  type_state (5x64)  ciphertext-side state to invert.
REQ-007 SHALL have port valid_o  output  1  state_o holds a complete result.
REQ-008 SHALL have port ack_i  input  1  consumer accepts the result while valid_o=1.
REQ-009 SHALL have port state_o  output  type_state (5x64)  inverse-substituted state.

Function
REQ-010 SHALL apply, for each column i (0..63), inverse S-box to the 5-bit word {x0[i],x1[i],x2[i],x3[i],x4[i]} (x0 MSB), writing the result back into the same bit positions.
REQ-011 SHALL use inverse table (index 0..31): 14 1A 07 0D 00 09 0E 12 0A 06 1D 01 19 15 13 1E 18 16 0B 11 03 05 1C 1F 17 1B 04 08 0F 0C 10 02 (hex).
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 In IDLE, ready_o=1, valid_o=0; on start_i=1: capture state_i into the working register, clear column counter, go to BUSY.
REQ-014 In BUSY, each cycle SHALL replace columns [cnt*COLS_PER_CYCLE +: COLS_PER_CYCLE] of the working register and increment cnt; ready_o=0.
REQ-015 After the last slice (cnt = 64/COLS_PER_CYCLE-1), SHALL go to DONE; latency from accepting edge to valid_o=1 is exactly 64/COLS_PER_CYCLE cycles (8 by default).
REQ-016 In DONE, valid_o=1 and state_o stable until ack_i=1; on ack_i, go to IDLE next cycle (no back-to-back accept in the ack cycle).
REQ-017 start_i while BUSY or DONE SHALL be ignored and SHALL NOT corrupt the working register.
REQ-018 state_o SHALL be driven from the working register at all times; contents are only guaranteed when valid_o=1.
REQ-019 Column counter width SHALL be clog2(64/COLS_PER_CYCLE), minimum 1 bit; it SHALL not wrap during BUSY.
REQ-020 ack_i outside DONE SHALL be ignored.

Reset
REQ-021 resetb_i=0 SHALL asynchronously force FSM=IDLE, counter=0, working register=0, so ready_o=1, valid_o=0, state_o=0.
REQ-022 Reset asserted mid-BUSY or in DONE SHALL abort the operation with no result; first accept is possible on the first edge after release.

Structure
REQ-023 type_state and the inverse table constant SHALL live in ascon_pack; COLS_PER_CYCLE stays a module parameter.
REQ-024 A combinational sub-module inv_sbox (5-bit in, 5-bit out) SHALL be instantiated COLS_PER_CYCLE times via generate.
REQ-025 Synthesizable, no latches, single clock domain.

Verification
REQ-026 Reset: resetb_i=0 mid-operation -> immediately ready_o=1, valid_o=0, state_o=0.
REQ-027 All-zero state, default parameter -> valid_o rises 8 cycles after accept; x0=x2=FFFFFFFFFFFFFFFF, x1=x3=x4=0.
REQ-028 Round trip: state with x2=all ones, others 0 (forward S-box of zero) -> result all zeros.
REQ-029 Random 1000 states through forward substitution then this block -> identity; checked for COLS_PER_CYCLE = 1, 8, 64 (latencies 64, 8, 1).
REQ-030 Backpressure: ack_i held 0 for 20 cycles with start_i pulsed -> valid_o and state_o unchanged, ready_o=0 until ack cycle +1.
REQ-031 Exhaustive column check: 32 states with column i = value i (i<32) -> column i equals table entry i.
